// File: rtl/debug_capture_arbiter.sv
// rtl/debug_capture_arbiter.sv - debug RAM capture controller and SPI read-port arbiter
//
// Records a trigger-started burst of 30-bit samples into a single-port debug
// RAM, then hands the RAM to the SPI read port once capture is DONE.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   arm, trigger, abort   capture control (priority abort > arm > trigger)
//   sample_valid/_data    datapath samples to capture
//   spi_rd_en/_addr/_data SPI read port (3-cycle read latency)
//   ram_we/re/addr/wdata  RAM command port (registered)
//   ram_rdata             RAM read data, valid one cycle after ram_re
//   status                {state, full, read_blocked, 4'b0}
//   capture_count         words written in the current or last capture
module debug_capture_arbiter #(
  parameter int DEPTH = 262144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arm,
  input  logic        trigger,
  input  logic        abort,
  input  logic        sample_valid,
  input  logic [29:0] sample_data,
  input  logic        spi_rd_en,
  input  logic [17:0] spi_rd_addr,
  output logic [29:0] spi_rd_data,
  output logic        ram_we,
  output logic        ram_re,
  output logic [17:0] ram_addr,
  output logic [29:0] ram_wdata,
  input  logic [29:0] ram_rdata,
  output logic [7:0]  status,
  output logic [18:0] capture_count
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_ARMED   = 2'd1;
  localparam logic [1:0]  S_CAPTURE = 2'd2;
  localparam logic [1:0]  S_DONE    = 2'd3;
  localparam logic [17:0] LAST_ADDR = 18'(DEPTH - 1);

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [17:0] wr_ptr;
  logic        full;
  logic        read_blocked;

  // Read pipeline: a miss/blocked read travels alongside real reads so that
  // spi_rd_data is always updated with the same 3-cycle latency, in order.
  logic        rd_zero1;
  logic        rd_zero2;
  logic        rd_pend;

  logic        accept;
  logic        last_write;
  logic        arm_clear;
  logic        rd_issue;
  logic        rd_zero;
  logic        rd_block;

  assign last_write = accept && (wr_ptr == LAST_ADDR);
  assign status     = {state, full, read_blocked, 4'b0000};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (arm) next_state = S_ARMED;
      end
      S_ARMED: begin
        if (abort)        next_state = S_IDLE;
        else if (arm)     next_state = S_ARMED;
        else if (trigger) next_state = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort || last_write) next_state = S_DONE;
      end
      default: begin
        if (arm) next_state = S_ARMED;
      end
    endcase
  end

  // Output decode: which events the datapath acts on this cycle
  always_comb begin
    accept    = 1'b0;
    arm_clear = 1'b0;
    rd_issue  = 1'b0;
    rd_zero   = 1'b0;
    rd_block  = 1'b0;
    case (state)
      S_IDLE: arm_clear = arm;
      S_ARMED: begin
        arm_clear = arm && !abort;
        // The trigger-cycle sample is the first word of the capture.
        accept    = sample_valid && trigger && !abort && !arm;
      end
      S_CAPTURE: accept = sample_valid && !abort;
      default:   arm_clear = arm;
    endcase
    if (spi_rd_en) begin
      if (state == S_DONE) begin
        if ({1'b0, spi_rd_addr} < capture_count) rd_issue = 1'b1;
        else                                     rd_zero  = 1'b1;
      end else begin
        rd_zero  = 1'b1;
        rd_block = 1'b1;
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      capture_count <= '0;
      full          <= 1'b0;
      read_blocked  <= 1'b0;
      ram_we        <= 1'b0;
      ram_re        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      rd_zero1      <= 1'b0;
      rd_zero2      <= 1'b0;
      rd_pend       <= 1'b0;
      spi_rd_data   <= '0;
    end else begin
      // accept and rd_issue depend on different states, so they never coincide.
      ram_we <= accept;
      ram_re <= rd_issue;
      if (accept) begin
        ram_addr  <= wr_ptr;
        ram_wdata <= sample_data;
      end else if (rd_issue) begin
        ram_addr  <= spi_rd_addr;
      end

      if (arm_clear) begin
        wr_ptr        <= '0;
        capture_count <= '0;
        full          <= 1'b0;
        read_blocked  <= 1'b0;
      end else begin
        if (accept) begin
          capture_count <= capture_count + 19'd1;
          // wr_ptr parks on the last address; the capture ends there.
          if (last_write) full   <= 1'b1;
          else            wr_ptr <= wr_ptr + 18'd1;
        end
        if (rd_block) read_blocked <= 1'b1;
      end

      rd_zero1 <= rd_zero;
      rd_zero2 <= rd_zero1;
      rd_pend  <= ram_re;
      if (rd_pend)       spi_rd_data <= ram_rdata;
      else if (rd_zero2) spi_rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_debug_capture_arbiter.sv
// tb/tb_debug_capture_arbiter.sv - self-checking bench for debug_capture_arbiter
module tb_debug_capture_arbiter;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic        trigger;
  logic        abort;
  logic        sample_valid;
  logic [29:0] sample_data;
  logic        spi_rd_en;
  logic [17:0] spi_rd_addr;
  logic [29:0] spi_rd_data;
  logic        ram_we;
  logic        ram_re;
  logic [17:0] ram_addr;
  logic [29:0] ram_wdata;
  logic [29:0] ram_rdata;
  logic [7:0]  status;
  logic [18:0] capture_count;

  int compared   = 0;
  int mismatched = 0;
  int overlap    = 0;

  // Reference model: what the RAM should hold and how many words were captured.
  logic [29:0] exp_mem [0:DEPTH-1];
  int          model_count = 0;

  logic [29:0] ram_mem [0:DEPTH-1];

  debug_capture_arbiter #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .trigger      (trigger),
    .abort        (abort),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .spi_rd_en    (spi_rd_en),
    .spi_rd_addr  (spi_rd_addr),
    .spi_rd_data  (spi_rd_data),
    .ram_we       (ram_we),
    .ram_re       (ram_re),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .status       (status),
    .capture_count(capture_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr[2:0]] <= ram_wdata;
    if (ram_re) ram_rdata <= ram_mem[ram_addr[2:0]];
  end

  always @(negedge clk) begin
    if (ram_we === 1'b1 && ram_re === 1'b1) overlap++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] done_status();
    return {2'b11, (model_count >= DEPTH), 1'b0, 4'b0000};
  endfunction

  // Arm, trigger with the first sample, feed n samples with gaps, abort if not full.
  task automatic do_capture(input int n, input int max_gap, input bit seq_data);
    logic [29:0] d;
    int          g;
    bit          exp_we;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("arm_status", 32'(status), 32'h40);
    chk("arm_count", 32'(capture_count), 32'd0);
    model_count = 0;
    for (int i = 0; i < n; i++) begin
      d = seq_data ? 30'(i + 1) : 30'($urandom);
      sample_valid = 1'b1;
      sample_data  = d;
      trigger      = (i == 0);
      tick();
      sample_valid = 1'b0;
      trigger      = 1'b0;
      exp_we = (model_count < DEPTH);
      chk("cap_we", 32'(ram_we), 32'(exp_we));
      if (exp_we) begin
        chk("cap_addr", 32'(ram_addr), 32'(model_count));
        chk("cap_data", 32'(ram_wdata), 32'(d));
        exp_mem[model_count] = d;
        model_count++;
      end
      chk("cap_count", 32'(capture_count), 32'(model_count));
      chk("cap_status", 32'(status),
          (model_count >= DEPTH) ? 32'(done_status()) : 32'h80);
      g = seq_data ? 1 : int'($urandom_range(0, max_gap));
      repeat (g) begin
        tick();
        chk("gap_we", 32'(ram_we), 32'd0);
      end
    end
    if (model_count < DEPTH) begin
      abort        = 1'b1;
      sample_valid = 1'b1;
      sample_data  = 30'($urandom);
      tick();
      abort        = 1'b0;
      sample_valid = 1'b0;
      chk("abort_we", 32'(ram_we), 32'd0);
    end
    chk("done_status", 32'(status), 32'(done_status()));
    chk("done_count", 32'(capture_count), 32'(model_count));
  endtask

  task automatic do_read(input logic [17:0] addr);
    bit hit;
    hit = (int'(addr) < model_count);
    spi_rd_en   = 1'b1;
    spi_rd_addr = addr;
    tick();
    spi_rd_en = 1'b0;
    chk("rd_re", 32'(ram_re), 32'(hit));
    if (hit) chk("rd_addr", 32'(ram_addr), 32'(addr));
    tick();
    tick();
    chk("rd_data", 32'(spi_rd_data), hit ? 32'(exp_mem[addr[2:0]]) : 32'd0);
    chk("rd_status", 32'(status), 32'(done_status()));
  endtask

  initial begin
    reset        = 1'b1;
    arm          = 1'b0;
    trigger      = 1'b0;
    abort        = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    spi_rd_en    = 1'b0;
    spi_rd_addr  = '0;
    tick();
    tick();
    chk("rst_status", 32'(status), 32'h00);
    chk("rst_count", 32'(capture_count), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_re", 32'(ram_re), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_rdata", 32'(spi_rd_data), 32'd0);
    reset = 1'b0;

    // Trigger in IDLE is ignored.
    trigger = 1'b1;
    sample_valid = 1'b1;
    tick();
    trigger = 1'b0;
    sample_valid = 1'b0;
    chk("idle_trig_status", 32'(status), 32'h00);
    chk("idle_trig_we", 32'(ram_we), 32'd0);

    // Short capture: samples 1..5 with idle gaps, then abort.
    do_capture(5, 1, 1'b1);
    do_read(18'd2);
    do_read(18'd6);
    for (int i = 0; i < 8; i++) do_read(18'($urandom_range(0, 11)));

    // Read attempt during CAPTURE is blocked; arm in CAPTURE is ignored.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    model_count = 0;
    trigger = 1'b1;
    sample_valid = 1'b1;
    sample_data = 30'($urandom);
    tick();
    trigger = 1'b0;
    sample_valid = 1'b0;
    spi_rd_en = 1'b1;
    spi_rd_addr = 18'd0;
    tick();
    spi_rd_en = 1'b0;
    chk("blk_re", 32'(ram_re), 32'd0);
    tick();
    tick();
    chk("blk_rdata", 32'(spi_rd_data), 32'd0);
    chk("blk_status", 32'(status), 32'h90);
    arm = 1'b1;
    sample_valid = 1'b1;
    sample_data = 30'h2AAA_5555;
    tick();
    arm = 1'b0;
    sample_valid = 1'b0;
    chk("cap_arm_we", 32'(ram_we), 32'd1);
    chk("cap_arm_addr", 32'(ram_addr), 32'd1);
    chk("cap_arm_count", 32'(capture_count), 32'd2);
    chk("cap_arm_status", 32'(status), 32'h90);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("blk_done_status", 32'(status), 32'hD0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("blk_clear_status", 32'(status), 32'h40);
    chk("blk_clear_count", 32'(capture_count), 32'd0);

    // Priority inside ARMED.
    arm = 1'b1;
    trigger = 1'b1;
    sample_valid = 1'b1;
    tick();
    chk("arm_trig_status", 32'(status), 32'h40);
    chk("arm_trig_we", 32'(ram_we), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    arm = 1'b0;
    trigger = 1'b0;
    sample_valid = 1'b0;
    chk("arm_abort_status", 32'(status), 32'h00);
    chk("arm_abort_we", 32'(ram_we), 32'd0);

    // Full buffer: 10 back-to-back samples into 8 words.
    do_capture(10, 0, 1'b0);
    for (int i = 0; i < 8; i++) do_read(18'(i));
    do_read(18'd8);

    // Random captures with random gaps.
    for (int r = 0; r < 4; r++) begin
      do_capture(int'($urandom_range(1, 11)), 2, 1'b0);
      for (int i = 0; i < 4; i++) do_read(18'($urandom_range(0, 9)));
    end

    // Reset held for two cycles mid-capture.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trigger = 1'b1;
    sample_valid = 1'b1;
    sample_data = 30'($urandom);
    tick();
    trigger = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("mrst_status", 32'(status), 32'h00);
    chk("mrst_count", 32'(capture_count), 32'd0);
    chk("mrst_we", 32'(ram_we), 32'd0);
    chk("mrst_re", 32'(ram_re), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    sample_valid = 1'b0;
    chk("post_rst_status", 32'(status), 32'h00);
    chk("post_rst_we", 32'(ram_we), 32'd0);

    chk("port_exclusive", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/debug_capture_arbiter.md
# debug_capture_arbiter

Capture controller and port arbiter for the single-port debug RAM behind the SPI debug-RAM opcodes (0xBA/0xBB). It records a trigger-started burst of 30-bit samples from an internal datapath into the RAM, then hands the RAM to the SPI block's read port. It also exports a status byte and a sample count suitable for the SPI debug8/debug32 registers.

## Interface
Parameters:
- DEPTH, 262144: RAM words; power of two, 2..2^18.

Ports:
- clk  in  1  main system clock
- reset  in  1  synchronous, active-high reset
- arm  in  1  single-cycle pulse; clears the count and waits for a trigger
- trigger  in  1  starts capture while ARMED
- abort  in  1  ends capture early (CAPTURE→DONE) or disarms (ARMED→IDLE)
- sample_valid  in  1  sample_data is valid this cycle
- sample_data  in  30  sample to capture
- spi_rd_en  in  1  SPI read-port enable (level, held for the transaction)
- spi_rd_addr  in  18  SPI read address
- spi_rd_data  out  30  read data returned to SPI
- ram_we  out  1  RAM write enable
- ram_re  out  1  RAM read enable
- ram_addr  out  18  shared RAM address
- ram_wdata  out  30  RAM write data
- ram_rdata  in  30  RAM read data; valid 1 cycle after ram_re
- status  out  8  {state[1:0], full, read_blocked, 4'b0}
- capture_count  out  19  words written in the current or last capture

## Operation
- States and encodings: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- Event priority: reset > abort > arm > trigger.
- IDLE:
  - arm → ARMED.
  - trigger, abort and samples are ignored.
- ARMED:
  - On entry (via arm): clear capture_count, full and read_blocked.
  - abort → IDLE.
  - trigger → CAPTURE. A sample_valid in the trigger cycle is written to address 0.
- CAPTURE:
  - Each sample_valid writes to address wr_ptr, then wr_ptr and capture_count increment.
  - After writing address DEPTH-1: set full and go to DONE. Later samples are dropped.
  - abort → DONE. A sample in the abort cycle is dropped.
  - arm and trigger are ignored.
- DONE:
  - The SPI owns the RAM.
  - arm → ARMED. trigger and abort are ignored.
- Read arbitration:
  - A read is issued only when state is DONE, spi_rd_en=1 and spi_rd_addr < capture_count.
  - spi_rd_en=1 in any other state: no RAM access, spi_rd_data=0, and read_blocked is set (sticky until arm or reset).
  - In DONE with spi_rd_addr ≥ capture_count: no RAM access and spi_rd_data=0. This does not set read_blocked.
- Port exclusivity:
  - ram_we and ram_re are never high in the same cycle.
  - Writes occur only from CAPTURE-accepted samples; reads only from DONE.
- Widths:
  - capture_count is 19 bits, so it can reach 2^18.
  - wr_ptr is 18 bits and never wraps, because capture stops at full.

## Timing
- Reset values:
  - state IDLE, wr_ptr 0, capture_count 0.
  - status 8'h00, spi_rd_data 0.
  - ram_we 0, ram_re 0, ram_addr 0, ram_wdata 0.
- All outputs are registered.
- Write path: a sample accepted in cycle N gives ram_we=1, ram_addr and ram_wdata in cycle N+1. capture_count updates in N+1.
- Final write: full is set and state=DONE in cycle N+1, in the same cycle as the last ram_we.
- Read path:
  - spi_rd_addr sampled in cycle N → ram_re and ram_addr in N+1.
  - ram_rdata is valid in N+2 and is registered to spi_rd_data in N+3.
  - Read latency is 3 cycles, well inside one SPI byte.
- The first read may be issued no earlier than the cycle after DONE is entered, so it never collides with the final write.
- spi_rd_data holds its last value while spi_rd_en=0.
- Reset mid-capture: in the next cycle state is IDLE and ram_we=0. The RAM contents are not cleared.

## Test plan
- Reset: hold reset for 2 cycles mid-capture → next cycle status=8'h00, capture_count=0, ram_we=0, ram_re=0.
- Short capture:
  - arm, then trigger with sample 30'h1 in the same cycle, then samples 30'h2..30'h5 with idle gaps, then abort.
  - Required: writes to addresses 0..4 with data 1..5, one cycle after each valid.
  - Required: capture_count=5, status=8'hC0.
- Full buffer (DEPTH=8): capture 10 back-to-back samples → exactly 8 writes (addresses 0..7), full=1, status=8'hE0, samples 9–10 dropped, capture_count=8.
- Read in DONE after the short capture:
  - spi_rd_en=1, spi_rd_addr=2 → ram_re one cycle later; spi_rd_data=30'h3 three cycles after the address.
  - spi_rd_addr=6 → spi_rd_data=0 with no ram_re.
- Read blocked: spi_rd_en=1 during CAPTURE → no ram_re, spi_rd_data=0, read_blocked=1. The next arm clears it (status=8'h40).
- Priority:
  - arm with abort while ARMED → IDLE.
  - trigger in IDLE → stays IDLE.
  - arm in CAPTURE → ignored, count continues.
